// File: rtl/test_basic3_reader.sv
// Blocking-port sink: sums each group of NUM_SAMPLES signed samples and offers the sum downstream.
// Optional per-addition saturation is enabled by defining TEST_BASIC3_READER_SAT_EN.
module test_basic3_reader #(
    parameter int NUM_SAMPLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] b_in,
    input  logic        b_in_sync,
    output logic        b_in_notify,
    output logic [31:0] s_out,
    input  logic        s_out_sync,
    output logic        s_out_notify
);

    // Handshake on both ports: a transfer occurs on a rising edge where notify=1 and sync=1.
    // Data is captured (b_in) or considered consumed (s_out) at that edge.

    typedef enum logic {
        SEC_READ  = 1'b0,
        SEC_WRITE = 1'b1
    } section_e;

    localparam logic [15:0] LAST_CNT = 16'(NUM_SAMPLES - 1);

    section_e    section_q, section_d;
    logic [31:0] acc_q, acc_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] s_out_q, s_out_d;
    logic [31:0] sum;

`ifdef TEST_BASIC3_READER_SAT_EN
    logic [32:0] wide;

    // Sign-extended add; bits 32 and 31 disagree exactly on signed overflow.
    always_comb begin
        wide = {acc_q[31], acc_q} + {b_in[31], b_in};
        if (wide[32] != wide[31]) begin
            sum = wide[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            sum = wide[31:0];
        end
    end
`else
    always_comb begin
        sum = acc_q + b_in;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            section_q <= SEC_READ;
            acc_q     <= 32'd0;
            cnt_q     <= 16'd0;
            s_out_q   <= 32'd0;
        end else begin
            section_q <= section_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            s_out_q   <= s_out_d;
        end
    end

    always_comb begin
        section_d = section_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        s_out_d   = s_out_q;
        case (section_q)
            SEC_READ: begin
                if (b_in_sync) begin
                    if (cnt_q == LAST_CNT) begin
                        s_out_d   = sum;
                        acc_d     = 32'd0;
                        cnt_d     = 16'd0;
                        section_d = SEC_WRITE;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            SEC_WRITE: begin
                if (s_out_sync) begin
                    section_d = SEC_READ;
                end
            end
            default: section_d = SEC_READ;
        endcase
    end

    // Notifies decode straight from the section flop, so they never depend on the sync inputs.
    assign b_in_notify  = (section_q == SEC_READ);
    assign s_out_notify = (section_q == SEC_WRITE);
    assign s_out        = s_out_q;

endmodule
